// File: rtl/timekeeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : timekeeper
//  Function : BCD time-of-day clock with button set, alarm and 7-segment out.
//  Revision : 1.0 - initial release
// ============================================================================
module timekeeper #(
    parameter int CLK_FREQ   = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int INIT_SEC   = 0,
    parameter int ALARM_INIT = 420,
    parameter int ALARM_LEN  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       alt_s,
    input  logic       alt_m,
    input  logic       alt_h,
    input  logic       alarm_sel,
    input  logic       alarm_en,
    input  logic       mode12,
    output logic       tick,
    output logic       alarm,
    output logic       pm,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam int c_DIV = CLK_FREQ / TICK_HZ;
    localparam int c_DW  = (c_DIV > 2) ? $clog2(c_DIV) : 1;
    localparam int c_AW  = $clog2(ALARM_LEN + 1);

    localparam int c_IH = INIT_SEC / 3600;
    localparam int c_IM = (INIT_SEC / 60) % 60;
    localparam int c_IS = INIT_SEC % 60;
    localparam int c_AH = ALARM_INIT / 60;
    localparam int c_AM = ALARM_INIT % 60;

    localparam logic [7:0] c_INIT_H  = 8'((c_IH / 10) * 16 + (c_IH % 10));
    localparam logic [7:0] c_INIT_M  = 8'((c_IM / 10) * 16 + (c_IM % 10));
    localparam logic [7:0] c_INIT_S  = 8'((c_IS / 10) * 16 + (c_IS % 10));
    localparam logic [7:0] c_ALM_H   = 8'((c_AH / 10) * 16 + (c_AH % 10));
    localparam logic [7:0] c_ALM_M   = 8'((c_AM / 10) * 16 + (c_AM % 10));
    localparam logic [6:0] c_BLANK   = 7'b1111111;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
        if (v == maxv)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return c_BLANK;
        endcase
    endfunction

    logic [c_DW-1:0] div_q, div_d;
    logic [2:0]      sync1_q, sync2_q, edge_q;
    logic [7:0]      hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic [7:0]      alm_h_q, alm_h_d, alm_m_q, alm_m_d;
    logic            tick_q;
    logic            alarm_q, alarm_d;
    logic [c_AW-1:0] acnt_q, acnt_d;

    logic [2:0] w_press;
    logic       w_tadj;
    logic       w_wrap;
    logic       w_adv;
    logic       w_match;
    logic [7:0] w_src_h, w_src_m;
    logic [4:0] w_hbin, w_hdisp;
    logic [3:0] w_htens, w_hunits;

    // Bit order {h, m, s}; synchroniser resets low so a held button cannot fire.
    assign w_press = edge_q & ~sync2_q;
    assign w_tadj  = (|w_press) && !alarm_sel;
    assign w_wrap  = run && (div_q == c_DW'(c_DIV - 1));
    assign w_adv   = w_wrap && !w_tadj;
    assign w_match = tick_q && (sec_q == 8'h00) && (hr_q == alm_h_q) && (min_q == alm_m_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            edge_q  <= 3'b000;
            div_q   <= '0;
            hr_q    <= c_INIT_H;
            min_q   <= c_INIT_M;
            sec_q   <= c_INIT_S;
            alm_h_q <= c_ALM_H;
            alm_m_q <= c_ALM_M;
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
            acnt_q  <= '0;
        end else begin
            sync1_q <= {alt_h, alt_m, alt_s};
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            div_q   <= div_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            alm_h_q <= alm_h_d;
            alm_m_q <= alm_m_d;
            tick_q  <= w_adv;
            alarm_q <= alarm_d;
            acnt_q  <= acnt_d;
        end
    end

    always_comb begin
        div_d = div_q;
        if (w_press[0] && !alarm_sel)
            div_d = '0;
        else if (run)
            div_d = w_wrap ? '0 : div_q + c_DW'(1);
    end

    // A time-adjust press wins over a coincident tick.
    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        alm_h_d = alm_h_q;
        alm_m_d = alm_m_q;
        if (w_adv) begin
            sec_d = bcd_inc(sec_q, 8'h59);
            if (sec_q == 8'h59) begin
                min_d = bcd_inc(min_q, 8'h59);
                if (min_q == 8'h59)
                    hr_d = bcd_inc(hr_q, 8'h23);
            end
        end else if (!alarm_sel) begin
            if (w_press[0]) sec_d = 8'h00;
            if (w_press[1]) min_d = bcd_inc(min_q, 8'h59);
            if (w_press[2]) hr_d  = bcd_inc(hr_q, 8'h23);
        end
        if (alarm_sel) begin
            if (w_press[1]) alm_m_d = bcd_inc(alm_m_q, 8'h59);
            if (w_press[2]) alm_h_d = bcd_inc(alm_h_q, 8'h23);
        end
    end

    always_comb begin
        alarm_d = alarm_q;
        acnt_d  = acnt_q;
        if (!alarm_en || (|w_press)) begin
            alarm_d = 1'b0;
        end else if (w_match) begin
            alarm_d = 1'b1;
            acnt_d  = '0;
        end else if (alarm_q && tick_q) begin
            if (acnt_q == c_AW'(ALARM_LEN - 1))
                alarm_d = 1'b0;
            else
                acnt_d = acnt_q + c_AW'(1);
        end
    end

    assign tick  = tick_q;
    assign alarm = alarm_q && alarm_en;

    assign w_src_h = alarm_sel ? alm_h_q : hr_q;
    assign w_src_m = alarm_sel ? alm_m_q : min_q;
    assign w_hbin  = 5'(w_src_h[7:4]) * 5'd10 + 5'(w_src_h[3:0]);
    assign pm      = (w_hbin >= 5'd12);

    always_comb begin
        w_hdisp = w_hbin;
        if (mode12) begin
            if (w_hbin == 5'd0)
                w_hdisp = 5'd12;
            else if (w_hbin > 5'd12)
                w_hdisp = w_hbin - 5'd12;
        end
        if (w_hdisp >= 5'd20) begin
            w_htens  = 4'd2;
            w_hunits = 4'(w_hdisp - 5'd20);
        end else if (w_hdisp >= 5'd10) begin
            w_htens  = 4'd1;
            w_hunits = 4'(w_hdisp - 5'd10);
        end else begin
            w_htens  = 4'd0;
            w_hunits = 4'(w_hdisp);
        end
    end

    assign HEX5 = seg(w_htens);
    assign HEX4 = seg(w_hunits);
    assign HEX3 = seg(w_src_m[7:4]);
    assign HEX2 = seg(w_src_m[3:0]);
    assign HEX1 = alarm_sel ? c_BLANK : seg(sec_q[7:4]);
    assign HEX0 = alarm_sel ? c_BLANK : seg(sec_q[3:0]);

endmodule
`default_nettype wire

// File: tb/tb_timekeeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_timekeeper
//  Function : Directed self-checking bench for timekeeper (4 clocks per tick).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timekeeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       alarm_sel;
    logic       alarm_en;
    logic       mode12;
    logic [2:0] btn = 3'b111;
    logic       tick, alarm, pm;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int n_checks = 0;
    int n_fail   = 0;

    timekeeper #(
        .CLK_FREQ  (4),
        .TICK_HZ   (1),
        .INIT_SEC  (86399),
        .ALARM_INIT(420),
        .ALARM_LEN (60)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .alt_s    (btn[0]),
        .alt_m    (btn[1]),
        .alt_h    (btn[2]),
        .alarm_sel(alarm_sel),
        .alarm_en (alarm_en),
        .mode12   (mode12),
        .tick     (tick),
        .alarm    (alarm),
        .pm       (pm),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dec(input logic [6:0] s);
        case (s)
            7'b1000000: return 4'd0;
            7'b1111001: return 4'd1;
            7'b0100100: return 4'd2;
            7'b0110000: return 4'd3;
            7'b0011001: return 4'd4;
            7'b0010010: return 4'd5;
            7'b0000010: return 4'd6;
            7'b1111000: return 4'd7;
            7'b0000000: return 4'd8;
            7'b0010000: return 4'd9;
            7'b1111111: return 4'hF;
            default:    return 4'hE;
        endcase
    endfunction

    // Six displayed digits packed as hhmmss; a blank digit reads as F.
    function automatic logic [23:0] disp();
        return {dec(HEX5), dec(HEX4), dec(HEX3), dec(HEX2), dec(HEX1), dec(HEX0)};
    endfunction

    task automatic press(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            btn[b] = 1'b0;
            repeat (4) @(negedge clk);
            btn[b] = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 20);
        check(tag, 32'(tick), 32'd1);
    endtask

    task automatic wait_alarm(input string tag, output logic prev_tick);
        int n = 0;
        prev_tick = 1'b0;
        do begin
            prev_tick = tick;
            @(negedge clk);
            n++;
        end while (!alarm && n < 400);
        check(tag, 32'(alarm), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic pt;
        int   n;
        int   cnt;

        rst = 1'b1; run = 1'b0; alarm_sel = 1'b0; alarm_en = 1'b0; mode12 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_disp", 32'(disp()), 32'h235959);
        check("rst_pm", 32'(pm), 32'd1);

        // Rollover: one tick exactly 4 cycles after release.
        rst = 1'b0; run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("div_tick_c%0d", i), 32'(tick), (i == 4) ? 32'd1 : 32'd0);
        end
        check("rollover_disp", 32'(disp()), 32'h000000);
        check("rollover_pm", 32'(pm), 32'd0);
        mode12 = 1'b1; #1;
        check("m12_midnight", 32'(disp()), 32'h120000);
        check("m12_midnight_pm", 32'(pm), 32'd0);
        mode12 = 1'b0;

        // Hold: run low freezes divider and time.
        run = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (tick) cnt++;
        end
        check("hold_ticks", 32'(cnt), 32'd0);
        check("hold_disp", 32'(disp()), 32'h000000);

        // Set 10:59 and measure minute-press latency without carry.
        press(2, 10);
        press(1, 59);
        check("set_1059", 32'(disp()), 32'h105900);
        btn[1] = 1'b0;
        @(negedge clk);
        check("lat_c1", 32'(disp()), 32'h105900);
        @(negedge clk);
        check("lat_c2", 32'(disp()), 32'h105900);
        @(negedge clk);
        check("lat_c3", 32'(disp()), 32'h100000);
        repeat (8) @(negedge clk);
        check("held_once", 32'(disp()), 32'h100000);
        btn[1] = 1'b1;
        repeat (4) @(negedge clk);

        // 12-hour mapping of 13:00.
        press(2, 3);
        mode12 = 1'b1; #1;
        check("m12_13h", 32'(disp()), 32'h010000);
        check("m12_13h_pm", 32'(pm), 32'd1);
        mode12 = 1'b0; #1;
        check("m24_13h", 32'(disp()), 32'h130000);

        // Seconds-clear press landing on the wrap cycle.
        run = 1'b1;
        wait_tick("tick_a");
        wait_tick("tick_b");
        check("pre_clear", 32'(disp()), 32'h130002);
        @(negedge clk);
        btn[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("clear_sec", 32'(disp()), 32'h130000);
        check("clear_no_tick", 32'(tick), 32'd0);
        btn[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 10);
        check("div_restart", 32'(n), 32'd4);
        check("after_restart", 32'(disp()), 32'h130001);

        // Alarm at 07:00 from 06:59:00.
        run = 1'b0;
        press(0, 1);
        press(2, 17);
        press(1, 59);
        check("set_0659", 32'(disp()), 32'h065900);
        alarm_sel = 1'b1; #1;
        check("alm_disp", 32'(disp()), 32'h0700FF);
        check("alm_pm", 32'(pm), 32'd0);
        alarm_sel = 1'b0;
        alarm_en = 1'b1; run = 1'b1;
        wait_alarm("alarm_rise1", pt);
        check("rise_after_tick", 32'(pt), 32'd1);
        check("rise_disp", 32'(disp()), 32'h070000);
        cnt = 0;
        n = 0;
        while (alarm && n < 400) begin
            @(negedge clk);
            n++;
            if (tick && alarm) cnt++;
        end
        check("alarm_fell", 32'(alarm), 32'd0);
        check("alarm_len", 32'(cnt), 32'd60);
        check("fall_disp", 32'(disp()), 32'h070100);

        // Adjust alarm while time runs; disarm clears at once.
        alarm_sel = 1'b1;
        press(1, 2);
        check("alm_0702", 32'(disp()), 32'h0702FF);
        alarm_sel = 1'b0; #1;
        check("time_kept", 32'(disp() >> 8), 32'h0701);
        wait_alarm("alarm_rise2", pt);
        repeat (2) @(negedge clk);
        check("alarm_active2", 32'(alarm), 32'd1);
        alarm_en = 1'b0; #1;
        check("disarm_now", 32'(alarm), 32'd0);
        @(negedge clk);
        alarm_en = 1'b1;
        @(negedge clk);
        check("disarm_cleared", 32'(alarm), 32'd0);

        // Reset mid-alarm, with the hours button held through release.
        alarm_sel = 1'b1;
        press(1, 1);
        alarm_sel = 1'b0;
        wait_alarm("alarm_rise3", pt);
        @(negedge clk);
        #2 rst = 1'b1; run = 1'b0; btn[2] = 1'b0;
        #1;
        check("arst_alarm", 32'(alarm), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_disp", 32'(disp()), 32'h235959);
        alarm_sel = 1'b1; #1;
        check("arst_alm", 32'(disp()), 32'h0700FF);
        alarm_sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("held_at_release", 32'(disp()), 32'h235959);
        btn[2] = 1'b1;
        repeat (4) @(negedge clk);
        press(2, 1);
        check("hour_wrap", 32'(disp()), 32'h005959);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
